regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised register file with a per-register pending-write scoreboard, used by the ID stage of the 5-stage pipeline.
- Generalises the fixed 16x16-bit, 2-read-port register file. Adds configurable width, depth and read-port count, plus WB-to-ID write-through bypass.
- Adds RAW hazard detection: produces `stall` for the IF/ID and ID/EXE pipeline registers.
- Writes come from the MEM/WB stage. Issues come from the ID stage as each instruction enters EXE.

Parameters:
- DW, 16, data width in bits.
- NREG, 16, number of registers; power of two, >= 2.
- NRD, 2, number of read ports.
- MAXPEND, 3, maximum in-flight writes per register; counter width CW = $clog2(MAXPEND+1).
- AW, $clog2(NREG), register address width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- raddr  in  NRD*AW  read addresses, packed; port i is bits [i*AW +: AW].
- rused  in  NRD  read port i is a real source operand this cycle.
- rdata  out  NRD*DW  read data, packed the same way as raddr.
- iss_valid  in  1  ID has an instruction that wants to issue.
- iss_wen  in  1  the issuing instruction writes a register.
- iss_waddr  in  AW  destination register of the issuing instruction.
- iss_ack  out  1  issue accepted this cycle; equals iss_valid & ~stall.
- stall  out  1  hazard; hold IF/ID, inject a bubble into ID/EXE.
- wb_wen  in  1  writeback write enable from MEM/WB.
- wb_waddr  in  AW  writeback register address.
- wb_wdata  in  DW  writeback data.
- err_underflow  out  1  sticky: a writeback hit a register with pending count 0.

Behaviour:
- Reset: clk and rst behave as already decided — one clock; synchronous, active-high reset. While rst is high at a rising edge:
  - all registers are cleared to 0, all pending counters to 0, and err_underflow to 0;
  - wb_wen and iss_valid are ignored on that edge.
  - Reset mid-operation discards all in-flight pending state.
- Register 0: always reads 0. Writes to it are ignored and it is never marked pending. An issue with iss_waddr == 0 is accepted but changes no counter.
- Read path: combinational, zero latency. For each port i:
  - rdata[i] = wb_wdata if wb_wen and wb_waddr == raddr[i] and raddr[i] != 0;
  - otherwise rdata[i] = reg[raddr[i]].
- Write path: if wb_wen and wb_waddr != 0, reg[wb_waddr] <= wb_wdata at the edge.
- Pending counter cnt[r] updates each edge (r != 0). Let inc = iss_ack & iss_wen & (iss_waddr == r) and dec = wb_wen & (wb_waddr == r):
  - inc and dec both set: unchanged.
  - inc only: cnt + 1.
  - dec only: cnt - 1 if cnt > 0. If cnt == 0, cnt stays 0 and err_underflow is set (sticky until rst).
- Hazard, port i, combinationally: rused[i] and raddr[i] != 0 and eff_cnt(raddr[i]) > 0.
  - eff_cnt(r) = cnt[r] - (wb_wen & wb_waddr == r), saturating at 0.
  - This means a writeback resolving the last pending write clears the hazard in the same cycle, via the bypass.
- Structural hazard: iss_valid and iss_wen and iss_waddr != 0 and cnt[iss_waddr] == MAXPEND, unless dec applies to iss_waddr this cycle.
- stall = iss_valid & (any port hazard | structural hazard). stall is 0 whenever iss_valid is 0.
- rdata has no reset value of its own; during reset it follows the read path. Registers are 0 in the cycle after reset.

Optional Feature:
- Macro: REGFILE_SB_DBG_EN.
- With the macro defined, three extra ports exist:
  - dbg_addr, in, AW: debug read address.
  - dbg_data, out, DW: reg[dbg_addr], unbypassed and combinational.
  - dbg_wcount, out, 16: number of accepted non-zero writebacks. Reset to 0; wraps 0xFFFF to 0x0000.
- Without the macro, these ports and the logic behind them are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - the default widths: DW = 16, NREG = 16;
  - the ALU-op and opcode constants already used by the pipeline;
  - the localparam-style function clog2 for counter sizing.
- One sub-module, sb_counter: a single saturating CW-bit up/down pending counter with inc/dec/underflow. It is instantiated NREG-1 times in a generate loop.

Test Plan:
- Reset, then write wb_waddr=3, wb_wdata=0x1234; next cycle raddr0=3 -> rdata0=0x1234. raddr1=0 -> rdata1=0, and stays 0 after any write to reg 0.
- Same-cycle bypass: wb_wen=1, wb_waddr=5, wb_wdata=0xBEEF, raddr1=5 -> rdata1=0xBEEF in the same cycle, before the edge.
- RAW stall: issue write to r4 (iss_ack=1). Next cycle iss_valid=1, raddr0=4, rused0=1 -> stall=1, iss_ack=0. Writeback r4 that cycle -> stall=0 with the bypassed data.
- Saturation: MAXPEND=3, three accepted issues to r7 with no writeback. The fourth issue to r7 -> stall=1. Simultaneous writeback to r7 -> iss_ack=1 and cnt stays 3.
- Underflow: writeback to r9 with cnt=0 -> err_underflow=1 and held. rst=1 for one edge -> err_underflow=0 and all cnt=0.
- rused gating: raddr0=4 pending but rused0=0 -> stall=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline package: default datapath sizes, ALU-op and opcode
// encodings, and a constant clog2 helper for sizing counters and addresses.
package cpu_pkg;

    localparam int DW_DEF   = 16;
    localparam int NREG_DEF = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ALU  = 4'h1,
        OP_ADDI = 4'h2,
        OP_LD   = 4'h3,
        OP_ST   = 4'h4,
        OP_BEQ  = 4'h5,
        OP_BNE  = 4'h6,
        OP_JMP  = 4'h7
    } opcode_e;

    // Smallest n with 2**n >= v (0 for v <= 1); usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one register: counts issued-but-not-written-back
// writes, holds on simultaneous inc/dec, saturates at MAXPEND and clamps at 0,
// flagging a decrement at 0 as underflow (combinational pulse).
module sb_counter
    import cpu_pkg::*;
#(
    parameter int MAXPEND = 3,
    parameter int CW      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          uf_o
);

    localparam logic [CW-1:0] MAXC = CW'(MAXPEND);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          uf;

    // Next count: inc/dec cancel; clamp at both ends.
    always_comb begin
        cnt_d = cnt_q;
        uf    = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q != MAXC) cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) uf = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter state; reset discards in-flight writes.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign uf_o  = uf;

endmodule

// File: rtl/regfile_sb.sv
// Register file with WB->ID bypass and per-register pending-write scoreboard.
// Generates RAW and structural (pending-count full) stalls for the ID stage.
// Optional debug port set enabled by defining REGFILE_SB_DBG_EN.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int NRD     = 2,
    parameter int MAXPEND = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NRD*cpu_pkg::clog2(NREG)-1:0] raddr,
    input  logic [NRD-1:0]                  rused,
    output logic [NRD*DW-1:0]               rdata,
    input  logic                            iss_valid,
    input  logic                            iss_wen,
    input  logic [cpu_pkg::clog2(NREG)-1:0] iss_waddr,
    output logic                            iss_ack,
    output logic                            stall,
    input  logic                            wb_wen,
    input  logic [cpu_pkg::clog2(NREG)-1:0] wb_waddr,
    input  logic [DW-1:0]                   wb_wdata,
`ifdef REGFILE_SB_DBG_EN
    input  logic [cpu_pkg::clog2(NREG)-1:0] dbg_addr,
    output logic [DW-1:0]                   dbg_data,
    output logic [15:0]                     dbg_wcount,
`endif
    output logic                            err_underflow
);

    localparam int AW = clog2(NREG);
    localparam int CW = clog2(MAXPEND + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAXPEND);

    logic [DW-1:0]             regs_q [NREG];
    logic [NREG-1:0][CW-1:0]   cnt_all;
    logic [NREG-1:0]           uf_all;
    logic                      err_q;
    logic                      raw_haz;
    logic                      str_haz;
    logic [AW-1:0]             ra;
    logic                      wb_hit;

    // One pending counter per architectural register; r0 is never pending.
    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        if (r == 0) begin : g_zero
            assign cnt_all[r] = '0;
            assign uf_all[r]  = 1'b0;
        end else begin : g_sb
            sb_counter #(.MAXPEND(MAXPEND), .CW(CW)) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc_i (iss_ack && iss_wen && (iss_waddr == AW'(r))),
                .dec_i (wb_wen && (wb_waddr == AW'(r))),
                .cnt_o (cnt_all[r]),
                .uf_o  (uf_all[r])
            );
        end
    end

    // Read ports with same-cycle writeback bypass, plus per-port RAW check
    // using the count as it will be after this cycle's writeback.
    always_comb begin
        rdata   = '0;
        raw_haz = 1'b0;
        ra      = '0;
        wb_hit  = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra     = raddr[i*AW +: AW];
            wb_hit = wb_wen && (wb_waddr == ra);
            if (ra == '0)  rdata[i*DW +: DW] = '0;
            else if (wb_hit) rdata[i*DW +: DW] = wb_wdata;
            else           rdata[i*DW +: DW] = regs_q[ra];
            if (rused[i] && (ra != '0) && (cnt_all[ra] > CW'(wb_hit))) raw_haz = 1'b1;
        end
    end

    // Destination counter full, unless a writeback frees a slot this cycle.
    assign str_haz = iss_wen && (iss_waddr != '0) && (cnt_all[iss_waddr] == MAXC)
                     && !(wb_wen && (wb_waddr == iss_waddr));

    assign stall   = iss_valid && (raw_haz || str_haz);
    assign iss_ack = iss_valid && !stall;

    // Register array write; r0 is never written so it stays 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
        end else if (wb_wen && (wb_waddr != '0)) begin
            regs_q[wb_waddr] <= wb_wdata;
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)          err_q <= 1'b0;
        else if (|uf_all) err_q <= 1'b1;
    end

    assign err_underflow = err_q;

`ifdef REGFILE_SB_DBG_EN
    logic [15:0] wcount_q;

    // Count accepted non-zero writebacks, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) wcount_q <= '0;
        else if (wb_wen && (wb_waddr != '0)) wcount_q <= wcount_q + 16'd1;
    end

    assign dbg_data   = regs_q[dbg_addr];
    assign dbg_wcount = wcount_q;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb (default parameters: 16x16, 2 ports,
// MAXPEND 3). Each vector drives inputs at the falling edge and checks the
// combinational outputs before the next rising edge; state carries forward.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [7:0]  raddr;
    logic [1:0]  rused;
    logic [31:0] rdata;
    logic        iss_valid, iss_wen, iss_ack, stall;
    logic [3:0]  iss_waddr;
    logic        wb_wen;
    logic [3:0]  wb_waddr;
    logic [15:0] wb_wdata;
    logic        err_underflow;
`ifdef REGFILE_SB_DBG_EN
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] dbg_wcount;
`endif

    int n_vec;
    int n_err;

    regfile_sb dut (
        .clk           (clk),
        .rst           (rst),
        .raddr         (raddr),
        .rused         (rused),
        .rdata         (rdata),
        .iss_valid     (iss_valid),
        .iss_wen       (iss_wen),
        .iss_waddr     (iss_waddr),
        .iss_ack       (iss_ack),
        .stall         (stall),
        .wb_wen        (wb_wen),
        .wb_waddr      (wb_waddr),
        .wb_wdata      (wb_wdata),
`ifdef REGFILE_SB_DBG_EN
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data),
        .dbg_wcount    (dbg_wcount),
`endif
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [1:0]  ru;
        logic        iv;
        logic        iw;
        logic [3:0]  ia;
        logic [15:0] e0;
        logic [15:0] e1;
        logic        es;
        logic        ea;
        logic        ee;
    } vec_t;

    vec_t tv [26];

    function automatic vec_t mk(input logic wen, input logic [3:0] wa, input logic [15:0] wd,
                                input logic [3:0] ra0, input logic [3:0] ra1, input logic [1:0] ru,
                                input logic iv, input logic iw, input logic [3:0] ia,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input logic es, input logic ea, input logic ee);
        vec_t v;
        v.wen = wen; v.wa = wa; v.wd = wd; v.ra0 = ra0; v.ra1 = ra1; v.ru = ru;
        v.iv = iv; v.iw = iw; v.ia = ia; v.e0 = e0; v.e1 = e1;
        v.es = es; v.ea = ea; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got 0x%04h expected 0x%04h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wb_wen    = v.wen;
        wb_waddr  = v.wa;
        wb_wdata  = v.wd;
        raddr     = {v.ra1, v.ra0};
        rused     = v.ru;
        iss_valid = v.iv;
        iss_wen   = v.iw;
        iss_waddr = v.ia;
    endtask

    task automatic check(input int idx, input vec_t v);
        n_vec++;
        chk("rdata0", idx, rdata[15:0],  v.e0);
        chk("rdata1", idx, rdata[31:16], v.e1);
        chk("stall",  idx, {15'd0, stall},         {15'd0, v.es});
        chk("iss_ack", idx, {15'd0, iss_ack},      {15'd0, v.ea});
        chk("err_underflow", idx, {15'd0, err_underflow}, {15'd0, v.ee});
    endtask

    initial begin
        vec_t idle;
        n_vec = 0;
        n_err = 0;
`ifdef REGFILE_SB_DBG_EN
        dbg_addr = 4'd0;
`endif
        //              wen wa  wd        ra0 ra1 ru     iv iw ia   e0        e1        es ea ee
        tv[0]  = mk(0, 0, 16'h0000, 3, 0, 2'b00, 1, 1, 3, 16'h0000, 16'h0000, 0, 1, 0);
        tv[1]  = mk(1, 3, 16'h1234, 3, 0, 2'b11, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, 0);
        tv[2]  = mk(0, 0, 16'h0000, 3, 0, 2'b11, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, 0);
        tv[3]  = mk(1, 0, 16'hFFFF, 0, 0, 2'b11, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        tv[4]  = mk(0, 0, 16'h0000, 0, 3, 2'b00, 0, 0, 0, 16'h0000, 16'h1234, 0, 0, 0);
        tv[5]  = mk(0, 0, 16'h0000, 0, 0, 2'b00, 1, 1, 5, 16'h0000, 16'h0000, 0, 1, 0);
        tv[6]  = mk(1, 5, 16'hBEEF, 3, 5, 2'b00, 0, 0, 0, 16'h1234, 16'hBEEF, 0, 0, 0);
        tv[7]  = mk(0, 0, 16'h0000, 0, 0, 2'b00, 1, 1, 4, 16'h0000, 16'h0000, 0, 1, 0);
        tv[8]  = mk(0, 0, 16'h0000, 4, 0, 2'b01, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
        tv[9]  = mk(1, 4, 16'h4444, 4, 0, 2'b01, 1, 0, 0, 16'h4444, 16'h0000, 0, 1, 0);
        tv[10] = mk(0, 0, 16'h0000, 4, 0, 2'b00, 1, 1, 4, 16'h4444, 16'h0000, 0, 1, 0);
        tv[11] = mk(0, 0, 16'h0000, 4, 0, 2'b00, 1, 0, 0, 16'h4444, 16'h0000, 0, 1, 0);
        tv[12] = mk(0, 0, 16'h0000, 0, 4, 2'b10, 1, 0, 0, 16'h0000, 16'h4444, 1, 0, 0);
        tv[13] = mk(1, 4, 16'h5555, 4, 0, 2'b01, 0, 0, 0, 16'h5555, 16'h0000, 0, 0, 0);
        tv[14] = mk(0, 0, 16'h0000, 0, 0, 2'b00, 1, 1, 7, 16'h0000, 16'h0000, 0, 1, 0);
        tv[15] = mk(0, 0, 16'h0000, 0, 0, 2'b00, 1, 1, 7, 16'h0000, 16'h0000, 0, 1, 0);
        tv[16] = mk(0, 0, 16'h0000, 0, 0, 2'b00, 1, 1, 7, 16'h0000, 16'h0000, 0, 1, 0);
        tv[17] = mk(0, 0, 16'h0000, 0, 0, 2'b00, 1, 1, 7, 16'h0000, 16'h0000, 1, 0, 0);
        tv[18] = mk(1, 7, 16'h7777, 7, 0, 2'b00, 1, 1, 7, 16'h7777, 16'h0000, 0, 1, 0);
        tv[19] = mk(0, 0, 16'h0000, 7, 0, 2'b00, 1, 1, 7, 16'h7777, 16'h0000, 1, 0, 0);
        tv[20] = mk(1, 7, 16'h7000, 7, 0, 2'b00, 0, 0, 0, 16'h7000, 16'h0000, 0, 0, 0);
        tv[21] = mk(0, 0, 16'h0000, 7, 0, 2'b00, 1, 1, 7, 16'h7000, 16'h0000, 0, 1, 0);
        tv[22] = mk(0, 0, 16'h0000, 7, 0, 2'b00, 1, 1, 7, 16'h7000, 16'h0000, 1, 0, 0);
        tv[23] = mk(1, 9, 16'h9999, 9, 0, 2'b00, 0, 0, 0, 16'h9999, 16'h0000, 0, 0, 0);
        tv[24] = mk(0, 0, 16'h0000, 9, 0, 2'b00, 0, 0, 0, 16'h9999, 16'h0000, 0, 0, 1);
        tv[25] = mk(0, 0, 16'h0000, 9, 7, 2'b01, 1, 1, 7, 16'h9999, 16'h7000, 1, 0, 1);

        idle = mk(0, 0, 16'h0000, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);

        // Initial reset, then check the cleared state.
        rst = 1'b1;
        drive(idle);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(0, 0, 16'h0000, 3, 5, 2'b11, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
        #1;
        check(-1, mk(0, 0, 16'h0000, 3, 5, 2'b11, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            check(i, tv[i]);
        end

        // Reset with a pending r7 (cnt 3), a set error flag, and a
        // writeback/issue that must both be ignored on the reset edge.
        @(negedge clk);
        rst = 1'b1;
        drive(mk(1, 2, 16'h2222, 0, 0, 2'b00, 1, 1, 7, 16'h0000, 16'h0000, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        drive(mk(0, 0, 16'h0000, 7, 2, 2'b11, 1, 1, 7, 16'h0000, 16'h0000, 0, 1, 0));
        #1;
        check(100, mk(0, 0, 16'h0000, 7, 2, 2'b11, 1, 1, 7, 16'h0000, 16'h0000, 0, 1, 0));

        // r7 now has one pending write: reading it stalls; register 3 was cleared.
        @(negedge clk);
        drive(mk(0, 0, 16'h0000, 7, 3, 2'b01, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0));
        #1;
        check(101, mk(0, 0, 16'h0000, 7, 3, 2'b01, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0));

        // Writeback resolves it in the same cycle: no stall, bypassed data, no error.
        @(negedge clk);
        drive(mk(1, 7, 16'hA5A5, 7, 3, 2'b01, 1, 0, 0, 16'hA5A5, 16'h0000, 0, 1, 0));
        #1;
        check(102, mk(1, 7, 16'hA5A5, 7, 3, 2'b01, 1, 0, 0, 16'hA5A5, 16'h0000, 0, 1, 0));

        @(negedge clk);
        drive(mk(0, 0, 16'h0000, 7, 0, 2'b01, 1, 0, 0, 16'hA5A5, 16'h0000, 0, 1, 0));
        #1;
        check(103, mk(0, 0, 16'h0000, 7, 0, 2'b01, 1, 0, 0, 16'hA5A5, 16'h0000, 0, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
